// File: rtl/reg_file_pkg.sv
// Shared types and constants for the write-buffered register file.
// Build option: REG_FILE_BYPASS_EN enables read forwarding from the write buffer.
package reg_file_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] reg_idx_t;

  // One buffered write-back request.
  typedef struct packed {
    reg_idx_t          addr;
    logic [DATA_W-1:0] data;
  } wbuf_entry_t;

endpackage

// File: rtl/reg_file_wbuf_fifo.sv
// Write buffer: BUF_DEPTH-entry FIFO of wbuf_entry_t with wrapping pointers.
// Ports: clk, rst_n; push/push_entry enqueue at tail; pop dequeues head;
// entries/valid_c expose every slot for forwarding; head_ptr/tail_ptr,
// count (occupancy 0..BUF_DEPTH), full_c, empty_c.
module wbuf_fifo
  import reg_file_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 2,
  localparam int unsigned PTR_W    = $clog2(BUF_DEPTH),
  localparam int unsigned CNT_W    = $clog2(BUF_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  wbuf_entry_t          push_entry,
  input  logic                 pop,
  output wbuf_entry_t          entries [BUF_DEPTH],
  output logic [BUF_DEPTH-1:0] valid_c,
  output logic [PTR_W-1:0]     head_ptr,
  output logic [PTR_W-1:0]     tail_ptr,
  output logic [CNT_W-1:0]     count,
  output logic                 full_c,
  output logic                 empty_c
);

  wbuf_entry_t      mem_q [BUF_DEPTH];
  wbuf_entry_t      mem_d [BUF_DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next-state: push writes the tail slot, pop advances the head; both may
  // happen together, which leaves the occupancy unchanged.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    if (push) begin
      mem_d[tail_q] = push_entry;
      tail_d        = tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // A slot is live when its distance from the head is below the occupancy.
  always_comb begin
    valid_c = '0;
    for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
      valid_c[i] = CNT_W'(PTR_W'(i) - head_q) < count_q;
    end
  end

  assign entries  = mem_q;
  assign head_ptr = head_q;
  assign tail_ptr = tail_q;
  assign count    = count_q;
  assign full_c   = (count_q == CNT_W'(BUF_DEPTH));
  assign empty_c  = (count_q == '0);

endmodule

// File: rtl/reg_file_wbuf.sv
// 32 x 32-bit register file fed through a valid/ready write buffer.
// Ports: clk, rst_n (async, active-low); wr_valid/wr_ready/wr_addr/wr_data
// write handshake; E drains one buffer entry per cycle into the array;
// rd_addr_a/rd_data_a and rd_addr_b/rd_data_b combinational reads;
// pending = buffer occupancy.
// Build option: REG_FILE_BYPASS_EN forwards the youngest buffered write to reads.
module reg_file_wbuf
  import reg_file_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 2,
  localparam int unsigned PTR_W    = $clog2(BUF_DEPTH),
  localparam int unsigned CNT_W    = $clog2(BUF_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              E,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [CNT_W-1:0]  pending
);

  logic [DATA_W-1:0]    regs_q [NUM_REGS];
  logic [DATA_W-1:0]    regs_d [NUM_REGS];
  wbuf_entry_t          entries [BUF_DEPTH];
  wbuf_entry_t          head_entry;
  logic [BUF_DEPTH-1:0] entry_valid;
  logic [PTR_W-1:0]     head_ptr;
  logic [PTR_W-1:0]     tail_ptr;
  logic                 full_c;
  logic                 empty_c;
  logic                 push;
  logic                 pop;

  // Writes to register 0 complete the handshake but are dropped.
  assign wr_ready = !full_c;
  assign push     = wr_valid && wr_ready && (wr_addr != '0);
  assign pop      = E && !empty_c;

  wbuf_fifo #(.BUF_DEPTH(BUF_DEPTH)) u_wbuf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry ('{addr: wr_addr, data: wr_data}),
    .pop        (pop),
    .entries    (entries),
    .valid_c    (entry_valid),
    .head_ptr   (head_ptr),
    .tail_ptr   (tail_ptr),
    .count      (pending),
    .full_c     (full_c),
    .empty_c    (empty_c)
  );

  assign head_entry = entries[head_ptr];

  // Array update: commit the buffer head when draining.
  always_comb begin
    regs_d = regs_q;
    if (pop) begin
      regs_d[head_entry.addr] = head_entry.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read lookup; index 0 is hardwired to zero.
  function automatic logic [DATA_W-1:0] read_port(input reg_idx_t idx);
    logic [DATA_W-1:0] val;
    logic [PTR_W-1:0]  slot;
    val  = regs_q[idx];
    slot = '0;
`ifdef REG_FILE_BYPASS_EN
    // Walk oldest to youngest so the youngest match wins.
    for (int unsigned k = 0; k < BUF_DEPTH; k++) begin
      slot = head_ptr + PTR_W'(k);
      if (entry_valid[slot] && (entries[slot].addr == idx)) begin
        val = entries[slot].data;
      end
    end
`endif
    if (idx == '0) begin
      val = '0;
    end
    return val;
  endfunction

  always_comb begin
    rd_data_a = read_port(rd_addr_a);
    rd_data_b = read_port(rd_addr_b);
  end

  logic unused_tail;
  assign unused_tail = ^tail_ptr;
`ifndef REG_FILE_BYPASS_EN
  logic unused_valid;
  assign unused_valid = ^entry_valid;
`endif

endmodule

// File: tb/tb_reg_file_wbuf.sv
// Directed bench for reg_file_wbuf; expectations adapt to REG_FILE_BYPASS_EN.
module tb_reg_file_wbuf;

  logic        clk;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        E;
  logic [4:0]  rd_addr_a;
  logic [31:0] rd_data_a;
  logic [4:0]  rd_addr_b;
  logic [31:0] rd_data_b;
  logic [1:0]  pending;

  int tests;
  int fails;

  reg_file_wbuf dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .E         (E),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (rd_data_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (rd_data_b),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b1;
    wr_valid  = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    E         = 1'b0;
    rd_addr_a = '0;
    rd_addr_b = '0;

    // Asynchronous reset between edges.
    #2 rst_n = 1'b0;
    #1;
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_ready", 32'(wr_ready), 32'd1);
    check("rst_rd0", rd_data_a, 32'd0);
    rd_addr_a = 5'd5;
    rd_addr_b = 5'd31;
    #1;
    check("rst_rd5", rd_data_a, 32'd0);
    check("rst_rd31", rd_data_b, 32'd0);
    #3 rst_n = 1'b1;
    step();

    // Basic write with drain enabled.
    E        = 1'b1;
    wr_valid = 1'b1;
    wr_addr  = 5'd5;
    wr_data  = 32'hDEADBEEF;
    step();
    wr_valid = 1'b0;
    check("basic_pending1", 32'(pending), 32'd1);
`ifdef REG_FILE_BYPASS_EN
    check("basic_rd_early", rd_data_a, 32'hDEADBEEF);
`else
    check("basic_rd_early", rd_data_a, 32'd0);
`endif
    step();
    check("basic_rd_commit", rd_data_a, 32'hDEADBEEF);
    check("basic_pending0", 32'(pending), 32'd0);

    // Fill the buffer with drain off.
    E        = 1'b0;
    wr_valid = 1'b1;
    wr_addr  = 5'd1;
    wr_data  = 32'h11;
    step();
    wr_addr  = 5'd2;
    wr_data  = 32'h22;
    step();
    check("full_pending", 32'(pending), 32'd2);
    check("full_ready", 32'(wr_ready), 32'd0);
    wr_addr   = 5'd3;
    wr_data   = 32'h33;
    rd_addr_a = 5'd3;
    rd_addr_b = 5'd1;
    step();
    check("stall_pending", 32'(pending), 32'd2);
    check("stall_rd3", rd_data_a, 32'd0);
`ifdef REG_FILE_BYPASS_EN
    check("stall_rd1", rd_data_b, 32'h11);
`else
    check("stall_rd1", rd_data_b, 32'd0);
`endif
    E = 1'b1;
    step();
    check("drain1_pending", 32'(pending), 32'd1);
    check("drain1_ready", 32'(wr_ready), 32'd1);
    check("drain1_rd1", rd_data_b, 32'h11);
    // Stalled request is accepted while the head drains: push and pop together.
    rd_addr_a = 5'd2;
    step();
    wr_valid = 1'b0;
    check("pushpop_pending", 32'(pending), 32'd1);
    check("pushpop_rd2", rd_data_a, 32'h22);
    rd_addr_a = 5'd3;
    step();
    check("drain3_pending", 32'(pending), 32'd0);
    check("drain3_rd3", rd_data_a, 32'h33);

    // Register zero writes are swallowed.
    E         = 1'b0;
    wr_valid  = 1'b1;
    wr_addr   = 5'd0;
    wr_data   = 32'hFFFFFFFF;
    rd_addr_a = 5'd0;
    #1;
    check("r0_ready", 32'(wr_ready), 32'd1);
    step();
    wr_valid = 1'b0;
    check("r0_pending", 32'(pending), 32'd0);
    check("r0_rd", rd_data_a, 32'd0);

    // Same-address ordering.
    wr_valid  = 1'b1;
    wr_addr   = 5'd7;
    wr_data   = 32'hA;
    rd_addr_b = 5'd7;
    step();
    wr_data = 32'hB;
    step();
    wr_valid = 1'b0;
    check("same_pending", 32'(pending), 32'd2);
`ifdef REG_FILE_BYPASS_EN
    check("same_rd_buf", rd_data_b, 32'hB);
`else
    check("same_rd_buf", rd_data_b, 32'd0);
`endif
    E = 1'b1;
    step();
    check("same_pending1", 32'(pending), 32'd1);
`ifdef REG_FILE_BYPASS_EN
    check("same_rd_mid", rd_data_b, 32'hB);
`else
    check("same_rd_mid", rd_data_b, 32'hA);
`endif
    step();
    check("same_pending0", 32'(pending), 32'd0);
    check("same_rd_final", rd_data_b, 32'hB);

    // Reset mid-operation discards buffered writes and clears the array.
    E         = 1'b0;
    wr_valid  = 1'b1;
    wr_addr   = 5'd9;
    wr_data   = 32'h99;
    rd_addr_a = 5'd5;
    rd_addr_b = 5'd9;
    step();
    wr_valid = 1'b0;
    check("mid_pending1", 32'(pending), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_pending", 32'(pending), 32'd0);
    check("mid_rst_rd5", rd_data_a, 32'd0);
    check("mid_rst_rd9", rd_data_b, 32'd0);
    rst_n = 1'b1;
    E     = 1'b1;
    step();
    step();
    check("mid_discard_rd9", rd_data_b, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
